// File: rtl/goal_referee.sv
// goal_referee: decides goals from per-frame ball samples, keeps tallies and flags gameover.
// Latency: goal pulse and tally update one cycle after the deciding frame tick; gameover one cycle after that.
// Backpressure: none; pulses are fire-and-forget and the next goal needs the ball to leave the mouth first.
//
// Ports:
//   CLK, Reset               clock, synchronous active-high reset
//   frame_tick               frame strobe; its rising edge is the sample point
//   ball_x, ball_y           ball centre coordinates
//   game_start               controller is in play
//   Reset_New                controller restart pulse; only acted on after gameover
//   patrick_goal/zuofu_goal  one-cycle goal pulses (right / left goal)
//   gameover                 level, from winning goal until Reset_New
//   patrick_tally/zuofu_tally saturating 3-bit scores
module goal_referee #(
  parameter int GOAL_LEFT_X    = 10,
  parameter int GOAL_RIGHT_X   = 629,
  parameter int GOAL_Y_TOP     = 180,
  parameter int GOAL_Y_BOT     = 300,
  parameter int CONFIRM_FRAMES = 2,
  parameter int WIN_SCORE      = 5
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  input  logic       game_start,
  input  logic       Reset_New,
  output logic       patrick_goal,
  output logic       zuofu_goal,
  output logic       gameover,
  output logic [2:0] patrick_tally,
  output logic [2:0] zuofu_tally
);

  typedef enum logic [2:0] {IDLE, ARMED, CONFIRM, SCORED, OVER} state_t;

  state_t     state, state_nxt;
  logic       frame_tick_q;
  logic [2:0] cnt, cnt_nxt;
  logic       side_r, side_r_nxt;   // 1 = right goal (patrick), 0 = left goal (zuofu)
  logic       patrick_goal_nxt, zuofu_goal_nxt, gameover_nxt;
  logic [2:0] patrick_tally_nxt, zuofu_tally_nxt;

  logic       tick, in_y, in_r, in_l, same_side;
  logic       award, award_r;
  logic [2:0] tally_old, tally_new;
  logic [3:0] cnt_inc;

  assign tick = frame_tick & ~frame_tick_q;
  assign in_y = (ball_y >= 10'(GOAL_Y_TOP)) && (ball_y <= 10'(GOAL_Y_BOT));
  assign in_r = in_y && (ball_x >= 10'(GOAL_RIGHT_X));
  // Right goal wins if both windows overlap (only possible with odd parameters).
  assign in_l = in_y && (ball_x <= 10'(GOAL_LEFT_X)) && !in_r;
  assign same_side = side_r ? in_r : in_l;
  assign cnt_inc   = {1'b0, cnt} + 4'd1;

  always_comb begin
    state_nxt         = state;
    cnt_nxt           = cnt;
    side_r_nxt        = side_r;
    patrick_goal_nxt  = 1'b0;
    zuofu_goal_nxt    = 1'b0;
    gameover_nxt      = gameover;
    patrick_tally_nxt = patrick_tally;
    zuofu_tally_nxt   = zuofu_tally;
    award             = 1'b0;
    award_r           = side_r;
    tally_old         = 3'd0;
    tally_new         = 3'd0;

    case (state)
      IDLE: begin
        if (game_start) state_nxt = ARMED;
      end
      ARMED: begin
        if (!game_start) begin
          state_nxt = IDLE;
          cnt_nxt   = 3'd0;
        end else if (tick && (in_r || in_l)) begin
          side_r_nxt = in_r;
          if (CONFIRM_FRAMES == 1) begin
            award   = 1'b1;
            award_r = in_r;
          end else begin
            cnt_nxt   = 3'd1;
            state_nxt = CONFIRM;
          end
        end
      end
      CONFIRM: begin
        if (!game_start) begin
          state_nxt = IDLE;
          cnt_nxt   = 3'd0;
        end else if (tick) begin
          if (same_side) begin
            if (cnt_inc >= 4'(CONFIRM_FRAMES)) begin
              award   = 1'b1;
              award_r = side_r;
            end else begin
              cnt_nxt = cnt_inc[2:0];
            end
          end else if (in_r || in_l) begin
            // Ball jumped straight into the other goal: restart the streak there.
            side_r_nxt = in_r;
            cnt_nxt    = 3'd1;
          end else begin
            cnt_nxt   = 3'd0;
            state_nxt = ARMED;
          end
        end
      end
      SCORED: begin
        if (!game_start) begin
          state_nxt = IDLE;
          cnt_nxt   = 3'd0;
        end else if (tick && !in_r && !in_l) begin
          state_nxt = ARMED;
        end
      end
      OVER: begin
        if (Reset_New) begin
          patrick_tally_nxt = 3'd0;
          zuofu_tally_nxt   = 3'd0;
          gameover_nxt      = 1'b0;
          state_nxt         = SCORED;
        end else begin
          gameover_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (award) begin
      cnt_nxt   = 3'd0;
      tally_old = award_r ? patrick_tally : zuofu_tally;
      tally_new = (tally_old == 3'd7) ? 3'd7 : tally_old + 3'd1;
      if (award_r) begin
        patrick_goal_nxt  = 1'b1;
        patrick_tally_nxt = tally_new;
      end else begin
        zuofu_goal_nxt  = 1'b1;
        zuofu_tally_nxt = tally_new;
      end
      state_nxt = (tally_new == 3'(WIN_SCORE)) ? OVER : SCORED;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state         <= IDLE;
      frame_tick_q  <= 1'b0;
      cnt           <= 3'd0;
      side_r        <= 1'b0;
      patrick_goal  <= 1'b0;
      zuofu_goal    <= 1'b0;
      gameover      <= 1'b0;
      patrick_tally <= 3'd0;
      zuofu_tally   <= 3'd0;
    end else begin
      state         <= state_nxt;
      frame_tick_q  <= frame_tick;
      cnt           <= cnt_nxt;
      side_r        <= side_r_nxt;
      patrick_goal  <= patrick_goal_nxt;
      zuofu_goal    <= zuofu_goal_nxt;
      gameover      <= gameover_nxt;
      patrick_tally <= patrick_tally_nxt;
      zuofu_tally   <= zuofu_tally_nxt;
    end
  end

endmodule

// File: tb/tb_goal_referee.sv
// tb_goal_referee: directed test-plan sequences plus random play against a frame-level referee model.
// Latency: expected goals are queued at the deciding input cycle and consumed one clock later.
// Backpressure: none; the monitor checks every cycle.
module tb_goal_referee;

  localparam int CF  = 2;
  localparam int WIN = 3;

  logic       CLK = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic [9:0] ball_x = 10'd320;
  logic [9:0] ball_y = 10'd240;
  logic       game_start = 1'b0;
  logic       Reset_New = 1'b0;
  logic       patrick_goal, zuofu_goal, gameover;
  logic [2:0] patrick_tally, zuofu_tally;

  goal_referee #(.CONFIRM_FRAMES(CF), .WIN_SCORE(WIN)) dut (
    .CLK(CLK), .Reset(Reset), .frame_tick(frame_tick), .ball_x(ball_x), .ball_y(ball_y),
    .game_start(game_start), .Reset_New(Reset_New), .patrick_goal(patrick_goal),
    .zuofu_goal(zuofu_goal), .gameover(gameover), .patrick_tally(patrick_tally),
    .zuofu_tally(zuofu_tally)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  typedef enum {M_IDLE, M_PLAY, M_LOCK, M_OVER} mmode_t;
  mmode_t mode = M_IDLE;
  bit     m_ftq = 0;
  int     streak = 0;
  int     streak_side = 0;       // 1 = right, 2 = left
  int     e_pt = 0, e_zt = 0;
  bit     e_go = 0;
  bit     goal_q[$];             // 1 = patrick goal, 0 = zuofu goal

  task automatic model_step();
    bit t;
    bit in_y;
    bit win;
    int side;
    t = frame_tick && !m_ftq;
    if (Reset) begin
      m_ftq = 0; mode = M_IDLE; streak = 0;
      e_pt = 0; e_zt = 0; e_go = 0;
      return;
    end
    m_ftq = frame_tick;
    in_y = (ball_y >= 180) && (ball_y <= 300);
    side = (in_y && ball_x >= 629) ? 1 : (in_y && ball_x <= 10) ? 2 : 0;
    case (mode)
      M_OVER: begin
        if (Reset_New) begin
          e_pt = 0; e_zt = 0; e_go = 0; mode = M_LOCK;
        end else e_go = 1;
      end
      M_IDLE: if (game_start) begin mode = M_PLAY; streak = 0; end
      default: begin
        if (!game_start) begin
          mode = M_IDLE; streak = 0;
        end else if (t) begin
          if (mode == M_LOCK) begin
            if (side == 0) mode = M_PLAY;
          end else begin
            if (side == 0) streak = 0;
            else if (side == streak_side && streak > 0) streak++;
            else begin streak_side = side; streak = 1; end
            if (streak >= CF) begin
              if (side == 1) begin
                e_pt = (e_pt == 7) ? 7 : e_pt + 1;
                win = (e_pt == WIN);
                goal_q.push_back(1'b1);
              end else begin
                e_zt = (e_zt == 7) ? 7 : e_zt + 1;
                win = (e_zt == WIN);
                goal_q.push_back(1'b0);
              end
              streak = 0;
              mode = win ? M_OVER : M_LOCK;
            end
          end
        end
      end
    endcase
  endtask

  // ---------------- monitor ----------------
  initial begin
    bit e;
    int exp_pg, exp_zg;
    forever begin
      @(posedge CLK);
      #2;
      exp_pg = 0; exp_zg = 0;
      if (goal_q.size() > 0) begin
        e = goal_q.pop_front();
        exp_pg = e ? 1 : 0;
        exp_zg = e ? 0 : 1;
      end
      chk("patrick_goal", int'(patrick_goal), exp_pg);
      chk("zuofu_goal", int'(zuofu_goal), exp_zg);
      chk("gameover", int'(gameover), int'(e_go));
      chk("patrick_tally", int'(patrick_tally), e_pt);
      chk("zuofu_tally", int'(zuofu_tally), e_zt);
    end
  end

  // ---------------- drivers ----------------
  task automatic drive(input bit ft, input int x, input int y, input bit gs, input bit rn,
                       input bit rst);
    @(negedge CLK);
    frame_tick = ft;
    ball_x = 10'(x);
    ball_y = 10'(y);
    game_start = gs;
    Reset_New = rn;
    Reset = rst;
    model_step();
  endtask

  bit gs_v = 1'b1;

  task automatic frame(input int x, input int y);
    drive(1'b1, x, y, gs_v, 1'b0, 1'b0);
    drive(1'b0, x, y, gs_v, 1'b0, 1'b0);
    drive(1'b0, x, y, gs_v, 1'b0, 1'b0);
  endtask

  task automatic frames(input int x, input int y, input int n);
    for (int i = 0; i < n; i++) frame(x, y);
  endtask

  task automatic do_reset();
    drive(1'b0, 320, 240, gs_v, 1'b0, 1'b1);
    drive(1'b0, 320, 240, gs_v, 1'b0, 1'b1);
  endtask

  int px[9] = '{640, 5, 320, 629, 10, 640, 5, 628, 11};
  int py[9] = '{240, 240, 240, 180, 300, 179, 301, 240, 240};

  initial begin
    int k, hold, low;
    bit rn, rst;
    model_step();             // first edge sees Reset=1 from time zero
    do_reset();

    // Patrick scores with two confirming frames, then is locked out while in the goal.
    gs_v = 1'b1;
    frames(640, 240, 2);
    frames(640, 240, 5);
    frame(320, 240);
    frames(640, 240, 2);
    // Aborted confirm on the left, out-of-window right frames.
    frame(5, 240); frame(320, 240); frame(5, 240);
    frame(320, 240);
    frames(640, 100, 10);

    // Zuofu wins 3-0 after a reset; lockout, Reset_New, rearm.
    do_reset();
    for (int g = 0; g < 3; g++) begin
      frames(5, 240, 2);
      frame(320, 240);
    end
    frames(5, 240, 1);
    frames(5, 240, 3);
    drive(1'b0, 5, 240, gs_v, 1'b1, 1'b0);
    frames(5, 240, 3);
    frame(320, 240);
    frames(5, 240, 2);
    // Reset_New outside gameover is ignored.
    drive(1'b0, 320, 240, gs_v, 1'b1, 1'b0);
    frame(320, 240);

    // Reset mid-confirm and with gameover set.
    frame(640, 240);
    do_reset();
    frame(640, 240);
    frames(5, 240, 2); frame(320, 240);
    frames(5, 240, 2); frame(320, 240);
    frames(5, 240, 2);
    frame(5, 240);
    do_reset();

    // A frame_tick held for 100 cycles is a single sample.
    for (int i = 0; i < 100; i++) drive(1'b1, 640, 240, gs_v, 1'b0, 1'b0);
    drive(1'b0, 640, 240, gs_v, 1'b0, 1'b0);
    frame(640, 240);
    frame(320, 240);

    // Random play.
    for (int f = 0; f < 600; f++) begin
      k = $urandom_range(0, 8);
      hold = $urandom_range(1, 3);
      low = $urandom_range(1, 4);
      if ($urandom_range(0, 29) == 0) gs_v = ~gs_v;
      else if (!gs_v && $urandom_range(0, 3) == 0) gs_v = 1'b1;
      for (int i = 0; i < hold; i++) drive(1'b1, px[k], py[k], gs_v, 1'b0, 1'b0);
      for (int i = 0; i < low; i++) begin
        rn  = ($urandom_range(0, 14) == 0);
        rst = ($urandom_range(0, 199) == 0);
        drive(1'b0, int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), gs_v, rn, rst);
      end
    end

    drive(1'b0, 320, 240, gs_v, 1'b0, 1'b0);
    drive(1'b0, 320, 240, gs_v, 1'b0, 1'b0);
    @(negedge CLK);
    chk("goal_queue_drained", goal_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
